// File: rtl/ospfb_frame_rx_pkg.sv
// Shared OSPFB definitions: input FSM states, status counter width and a saturating increment.
package ospfb_frame_rx_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } rx_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/ospfb_frame_rx_if.sv
// Sample stream from the OSPFB and frame stream toward the FFT, bundled for the frame receiver.
interface ospfb_frame_rx_if #(
    parameter int WIDTH = 16
);
    logic             s_tvalid;
    logic             s_tready;
    logic [WIDTH-1:0] s_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic [WIDTH-1:0] m_tdata;
    logic             m_tlast;

    modport slave (
        input  s_tvalid, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output s_tvalid, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/ospfb_frame_rx_sync_fifo.sv
// Single-clock FIFO with a registered output stage; occupancy includes the word held in the output register.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    mem_count;
    logic             pop;
    logic             load;

    assign pop       = rd_valid & rd_en;
    assign load      = (mem_count != '0) && (!rd_valid || pop);
    assign occupancy = mem_count + OW'(rd_valid);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The output register refills from memory whenever it is empty or being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_data  <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
            mem_count <= mem_count + OW'(wr_en) - OW'(load);
        end
    end

    no_write_when_full: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && !pop && occupancy == OW'(DEPTH)));

endmodule

// File: rtl/ospfb_frame_rx.sv
// Frames the free-running OSPFB sample stream into FFT_LEN frames, dropping whole frames when the buffer lacks room.
module ospfb_frame_rx
    import ospfb_frame_rx_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FFT_LEN = 32,
    parameter int DEPTH   = 2 * FFT_LEN
)(
    input  logic               clk,
    input  logic               rst,
    ospfb_frame_rx_if.slave    bus,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   frame_cnt
);
    localparam int IN_W  = $clog2(FFT_LEN);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    rx_state_e         state;
    rx_state_e         next_state;
    logic [IN_W-1:0]   in_ctr;
    logic [IN_W-1:0]   out_ctr;
    logic              beat;
    logic              frame_start;
    logic              wr_en;
    logic              drop_frame;
    logic              rd_hs;
    logic              fifo_valid;
    logic [WIDTH-1:0]  fifo_data;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W-1:0]  free_space;

    assign bus.s_tready = ~rst;
    assign beat         = bus.s_tvalid & bus.s_tready;
    assign rd_hs        = fifo_valid & bus.m_tready;
    assign frame_start  = beat && (in_ctr == '0);
    // A read on the same edge frees its slot in time for the incoming frame.
    assign free_space   = OCC_W'(DEPTH) - (occupancy - OCC_W'(rd_hs));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        drop_frame = 1'b0;
        if (frame_start) begin
            next_state = (free_space >= OCC_W'(FFT_LEN)) ? ACCEPT : DISCARD;
        end
        wr_en      = beat && (next_state == ACCEPT);
        drop_frame = frame_start && (next_state == DISCARD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ctr    <= '0;
            out_ctr   <= '0;
            drop_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            if (beat) begin
                in_ctr <= in_ctr + 1'b1;
            end
            if (rd_hs) begin
                out_ctr <= out_ctr + 1'b1;
            end
            if (drop_frame) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (wr_en && in_ctr == IN_W'(FFT_LEN - 1)) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (bus.s_tdata),
        .rd_en     (bus.m_tready),
        .rd_data   (fifo_data),
        .rd_valid  (fifo_valid),
        .occupancy (occupancy)
    );

    assign bus.m_tvalid = fifo_valid;
    assign bus.m_tdata  = fifo_data;
    assign bus.m_tlast  = fifo_valid && (out_ctr == IN_W'(FFT_LEN - 1));

endmodule
